warmboot_ctl: RTL and testbench

Produces S0/S1/BOOT for the iCE40 SB_WARMBOOT primitive. A CPU triggers reconfiguration into one of four flash images by writing an unlock sequence to an I/O port on the Z80-style bus. The block sits between the bus pins and the warmboot primitive, inside fpga20. It oversamples the asynchronous bus strobes on CLK1.

---
 rtl/warmboot_pkg.sv | 24 ++
 rtl/warmboot_ctl_if.sv | 13 +
 rtl/warmboot_ctl_bus_wr_detect.sv | 59 +++++
 rtl/warmboot_ctl.sv | 130 +++++++++++++
 tb/tb_warmboot_ctl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/warmboot_pkg.sv
// Shared constants and state encoding for the warmboot unlock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package warmboot_pkg;

  localparam logic [7:0] KEY1_BYTE = 8'hA5;
  localparam logic [7:0] KEY2_BYTE = 8'h5A;
  localparam logic [7:0] CMD_MASK  = 8'hFC;
  localparam logic [7:0] CMD_BASE  = 8'hB0;

  typedef enum logic [2:0] {
    IDLE,
    KEY1,
    KEY2,
    DELAY,
    BOOTING
  } state_t;

  // True for the four image-select command bytes 0xB0..0xB3.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b & CMD_MASK) == CMD_BASE;
  endfunction

endpackage

// File: rtl/warmboot_ctl_if.sv
// Z80-style I/O write bus as seen by fpga20 port blocks (all strobes active-low).
// Latency: n/a (wiring only).
// Backpressure: none; the bus cannot be stalled by a listener.
interface warmboot_ctl_if;
  logic       IORQ;
  logic       WR;
  logic       M1;
  logic [7:0] A;
  logic [7:0] D;

  modport master (output IORQ, WR, M1, A, D);
  modport slave  (input  IORQ, WR, M1, A, D);
endinterface

// File: rtl/warmboot_ctl_bus_wr_detect.sv
// Synchronizes async Z80 I/O-write strobes and emits one strobe per bus write with addr/data.
// Latency: wr_stb is high in the cycle after the second sync flop sees the write (3rd edge after WR falls).
// Backpressure: none; one single-cycle strobe per bus cycle, consumer must take it.
module bus_wr_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorq,
  input  logic       wr,
  input  logic       m1,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic       hit;
  logic       hit_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;

  // I/O write, not an interrupt acknowledge (M1 low with IORQ low).
  assign hit    = ~sync_b[2] & ~sync_b[1] & sync_b[0];
  assign wr_stb = hit & ~hit_q;

  // A/D have been stable since before WR fell, so use them directly on the
  // strobe cycle and keep a copy for later readers.
  assign wr_addr = wr_stb ? addr : addr_q;
  assign wr_data = wr_stb ? data : data_q;

  // Two-flop synchronizers; reset to the inactive (high) strobe level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 3'b111;
      sync_b <= 3'b111;
    end else begin
      sync_a <= {iorq, wr, m1};
      sync_b <= sync_a;
    end
  end

  // Edge-detect history and address/data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
    end else begin
      hit_q <= hit;
      if (wr_stb) begin
        addr_q <= addr;
        data_q <= data;
      end
    end
  end

endmodule

// File: rtl/warmboot_ctl.sv
// Unlock-sequence controller driving SB_WARMBOOT S0/S1/BOOT; optional LOCK input under WARMBOOT_LOCK_EN.
// Latency: state changes 3 CLK1 edges after WR falls; BOOT rises BOOT_DELAY cycles after S1:S0 latch.
// Backpressure: none; writes arriving in DELAY/BOOTING are silently ignored.
module warmboot_ctl
  import warmboot_pkg::*;
#(
  parameter logic [7:0] PORT_ADDR      = 8'hF0,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         BOOT_DELAY     = 16
) (
  input  logic           CLK1,
  input  logic           RESET,
`ifdef WARMBOOT_LOCK_EN
  input  logic           LOCK,
`endif
  warmboot_ctl_if.slave  bus,
  output logic           S0,
  output logic           S1,
  output logic           BOOT,
  output logic           ARMED
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  state_t        state, state_nxt;
  logic [1:0]    img, img_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [DW-1:0] dly, dly_nxt;
  logic          wr_stb;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          port_wr;
  logic          lock;

`ifdef WARMBOOT_LOCK_EN
  assign lock = LOCK;
`else
  assign lock = 1'b0;
`endif

  bus_wr_detect u_wr_detect (
    .clk     (CLK1),
    .rst     (RESET),
    .iorq    (bus.IORQ),
    .wr      (bus.WR),
    .m1      (bus.M1),
    .addr    (bus.A),
    .data    (bus.D),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  assign port_wr = wr_stb && (wr_addr == PORT_ADDR);

  // State, image select and counters.
  always_ff @(posedge CLK1) begin
    if (RESET) begin
      state <= IDLE;
      img   <= 2'b00;
      tmr   <= '0;
      dly   <= '0;
    end else begin
      state <= state_nxt;
      img   <= img_nxt;
      tmr   <= tmr_nxt;
      dly   <= dly_nxt;
    end
  end

  // Unlock sequencing, inter-write timeout and boot delay.
  always_comb begin
    state_nxt = state;
    img_nxt   = img;
    tmr_nxt   = tmr;
    dly_nxt   = dly;
    unique case (state)
      IDLE: begin
        tmr_nxt = '0;
        dly_nxt = '0;
        if (port_wr && wr_data == KEY1_BYTE) state_nxt = KEY1;
      end
      KEY1, KEY2: begin
        tmr_nxt = tmr + 1'b1;
        if (port_wr) begin
          // A write in the same cycle as the timeout takes precedence.
          tmr_nxt = '0;
          if (wr_data == KEY1_BYTE) begin
            state_nxt = KEY1;
          end else if (state == KEY1 && wr_data == KEY2_BYTE) begin
            state_nxt = KEY2;
          end else if (state == KEY2 && is_cmd(wr_data)) begin
            state_nxt = DELAY;
            img_nxt   = wr_data[1:0];
            dly_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end
      end
      DELAY: begin
        dly_nxt = dly + 1'b1;
        if (dly == DW'(BOOT_DELAY - 1)) state_nxt = BOOTING;
      end
      BOOTING: begin
        state_nxt = BOOTING;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // LOCK holds everything short of an already-committed boot in IDLE.
    if (lock && state != BOOTING) begin
      state_nxt = IDLE;
      img_nxt   = 2'b00;
      tmr_nxt   = '0;
      dly_nxt   = '0;
    end
  end

  assign S0    = img[0];
  assign S1    = img[1];
  assign BOOT  = (state == BOOTING);
  assign ARMED = (state == KEY1) || (state == KEY2) || (state == DELAY);

endmodule

// File: tb/tb_warmboot_ctl.sv
// Bench for warmboot_ctl: directed scenarios plus random unlock traffic against a timestamp model.
// Latency: n/a.
// Backpressure: n/a.
module tb_warmboot_ctl;

  localparam int T  = 1000;
  localparam int BD = 16;
  localparam logic [7:0] PORT = 8'hF0;

  logic CLK1 = 1'b0;
  logic RESET = 1'b0;
  logic LOCK = 1'b0;
  logic S0, S1, BOOT, ARMED;

  warmboot_ctl_if bus ();

  warmboot_ctl #(
    .PORT_ADDR      (PORT),
    .TIMEOUT_CYCLES (T),
    .BOOT_DELAY     (BD)
  ) dut (
    .CLK1  (CLK1),
    .RESET (RESET),
`ifdef WARMBOOT_LOCK_EN
    .LOCK  (LOCK),
`endif
    .bus   (bus),
    .S0    (S0),
    .S1    (S1),
    .BOOT  (BOOT),
    .ARMED (ARMED)
  );

  always #5 CLK1 = ~CLK1;

  int n_chk = 0;
  int n_err = 0;
  string phase = "reset";

  // Model: sequence progress plus timestamps; timeout and boot are derived
  // from elapsed cycles rather than from counters.
  int cyc = 0;
  int m_prog = 0;      // 0 none, 1 got A5, 2 got A5 5A, 3 command accepted
  int m_img = 0;
  int m_last = 0;      // edge of the last write that kept the sequence alive
  int m_boot_at = 0;   // edge after which BOOT is high
  int last_e = 0;
  bit p_on = 0;
  int p_e = 0;
  logic [7:0] p_a, p_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  // Effective progress after edge c: 4 means booting.
  function automatic int eff(input int c);
    if ((m_prog == 1 || m_prog == 2) && (c - m_last >= T)) return 0;
    if (m_prog == 3 && c >= m_boot_at) return 4;
    return m_prog;
  endfunction

  task automatic apply_event(input int e, input logic [7:0] a, input logic [7:0] d);
    int s;
    s = eff(e - 1);
    if (a != PORT) return;
    if (s == 3 || s == 4) return;
    if (d == 8'hA5) begin
      m_prog = 1; m_last = e;
    end else if (s == 1 && d == 8'h5A) begin
      m_prog = 2; m_last = e;
    end else if (s == 2 && d >= 8'hB0 && d <= 8'hB3) begin
      m_prog = 3; m_img = d - 8'hB0; m_boot_at = e + BD;
    end else begin
      m_prog = 0;
    end
  endtask

  task automatic tick();
    int s;
    logic [3:0] exp;
    @(posedge CLK1);
    cyc++;
    if (RESET) begin
      m_prog = 0; m_img = 0;
    end else if (LOCK && eff(cyc - 1) != 4) begin
      m_prog = 0; m_img = 0;
    end else if (p_on && p_e == cyc) begin
      apply_event(cyc, p_a, p_d);
    end
    if (p_on && p_e == cyc) p_on = 0;
    #1;
    s = eff(cyc);
    exp[3] = (s == 4);
    exp[2] = (s >= 1 && s <= 3);
    exp[1:0] = (s >= 3) ? m_img[1:0] : 2'b00;
    chk(phase, {28'd0, BOOT, ARMED, S1, S0}, {28'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d, input logic m1);
    bus.A = a; bus.D = d; bus.M1 = m1; bus.IORQ = 1'b0; bus.WR = 1'b0;
    if (m1) begin
      p_on = 1; p_e = cyc + 3; p_a = a; p_d = d; last_e = cyc + 3;
    end
    idle(4);
    bus.IORQ = 1'b1; bus.WR = 1'b1; bus.M1 = 1'b1;
    idle(3);
  endtask

  task automatic wr(input logic [7:0] d);
    bus_wr(PORT, d, 1'b1);
  endtask

  // Issue a port write whose event lands exactly on edge target.
  task automatic wr_at(input int target, input logic [7:0] d);
    while (cyc < target - 3) tick();
    wr(d);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle(2);
    RESET = 1'b0;
    idle(2);
  endtask

  initial begin
    int nw, r, gap, pick;
    logic [7:0] b;
    bus.IORQ = 1'b1; bus.WR = 1'b1; bus.M1 = 1'b1; bus.A = 8'h00; bus.D = 8'h00;
    RESET = 1'b1;
    @(posedge CLK1);
    #1;
    idle(2);
    RESET = 1'b0;
    idle(3);

    phase = "seq_b2";
    wr(8'hA5); idle(100); wr(8'h5A); idle(100); wr(8'hB2); idle(40);
    do_reset();

    phase = "wrong_port";
    wr(8'hA5); bus_wr(8'hF1, 8'h5A, 1'b1); idle(T + 10); wr(8'hB1); idle(20);
    wr(8'hA5); bus_wr(8'hF1, 8'h5A, 1'b1); wr(8'hB1); idle(20);

    phase = "timeout";
    wr(8'hA5); idle(T + 20); wr(8'h5A); wr(8'hB0); idle(40);

    phase = "tmo_edge_win";
    wr(8'hA5); wr_at(last_e + T, 8'h5A); wr_at(last_e + T, 8'hB1); idle(30);
    do_reset();
    phase = "tmo_edge_lose";
    wr(8'hA5); wr_at(last_e + T + 1, 8'h5A); wr(8'hB1); idle(30);

    phase = "rekey_intack";
    wr(8'hA5); wr(8'h5A); wr(8'hA5); bus_wr(PORT, 8'h5A, 1'b0);
    wr(8'h5A); bus_wr(PORT, 8'hB0, 1'b0); wr(8'hB3); idle(40);
    do_reset();

    phase = "reset_in_delay";
    wr(8'hA5); wr(8'h5A); wr(8'hB1);
    while (cyc < last_e + 5) tick();
    RESET = 1'b1; tick(); RESET = 1'b0;
    idle(30);
    phase = "after_reset";
    wr(8'hA5); wr(8'h5A); wr(8'hB2); idle(30);
    do_reset();

`ifdef WARMBOOT_LOCK_EN
    phase = "lock_full";
    LOCK = 1'b1; wr(8'hA5); wr(8'h5A); wr(8'hB2); idle(30); LOCK = 1'b0; idle(5);
    phase = "lock_delay";
    wr(8'hA5); wr(8'h5A); wr(8'hB3); LOCK = 1'b1; tick(); LOCK = 1'b0; idle(30);
    phase = "lock_booting";
    wr(8'hA5); wr(8'h5A); wr(8'hB1); idle(25); LOCK = 1'b1; idle(3); LOCK = 1'b0; idle(3);
    do_reset();
`endif

    phase = "random";
    for (int round = 0; round < 40; round++) begin
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        pick = $urandom_range(0, 9);
        if (pick <= 2) b = 8'hA5;
        else if (pick <= 4) b = 8'h5A;
        else if (pick <= 7) b = 8'hB0 + 8'($urandom_range(0, 3));
        else b = 8'($urandom_range(0, 255));
        r = $urandom_range(0, 19);
        if (r == 0) bus_wr(PORT, b, 1'b0);
        else if (r == 1) bus_wr(8'hF1, b, 1'b1);
        else if (r == 2) wr_at(last_e + T - 2 + $urandom_range(0, 4), b);
        else wr(b);
        gap = $urandom_range(0, 30);
        idle(gap);
      end
      idle(20);
      if ($urandom_range(0, 1) == 1) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
